// File: rtl/non_max_suppression.sv
// non_max_suppression: 3x3 streaming non-maximum suppression on gradient magnitude/direction.
// Optional NMS_LOW_CLAMP_EN: kept centres below LOW_CLAMP are zeroed.
module non_max_suppression #(
    parameter int          IMG_WIDTH  = 508,
    parameter int          IMG_HEIGHT = 508,
    parameter logic [10:0] LOW_CLAMP  = 11'd20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] nms_mag_in,
    input  logic [1:0]  nms_dir_in,
    input  logic        nms_data_in_valid,
    output logic [10:0] nms_mag_out,
    output logic [1:0]  nms_dir_out,
    output logic        nms_out_valid,
    output logic        nms_frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic {FILL, RUN} state_t;

    state_t        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [12:0]   lb1_q [IMG_WIDTH];
    logic [12:0]   lb2_q [IMG_WIDTH];
    logic [12:0]   win_q [3][3];
    logic [12:0]   win_d [3][3];
    logic [10:0]   c_mag, na, nb;
    logic [1:0]    c_dir;
    logic          keep, col_last, row_last, emit;

    assign col_last = col_q == CW'(IMG_WIDTH - 1);
    assign row_last = row_q == RW'(IMG_HEIGHT - 1);
    assign emit     = nms_data_in_valid && state_q == RUN && col_q >= CW'(2);

    // Window rows: 0 = row-2 (top), 1 = row-1 (centre), 2 = current row; column 2 is newest.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb2_q[col_q];
        win_d[1][2] = lb1_q[col_q];
        win_d[2][2] = {nms_mag_in, nms_dir_in};
        c_mag = win_d[1][1][12:2];
        c_dir = win_d[1][1][1:0];
        na = c_dir == 2'd0 ? win_d[1][0][12:2] :
             c_dir == 2'd1 ? win_d[0][2][12:2] :
             c_dir == 2'd2 ? win_d[0][1][12:2] : win_d[0][0][12:2];
        nb = c_dir == 2'd0 ? win_d[1][2][12:2] :
             c_dir == 2'd1 ? win_d[2][0][12:2] :
             c_dir == 2'd2 ? win_d[2][1][12:2] : win_d[2][2][12:2];
`ifdef NMS_LOW_CLAMP_EN
        keep = c_mag >= na && c_mag >= nb && c_mag >= LOW_CLAMP;
`else
        keep = c_mag >= na && c_mag >= nb;
`endif
    end

    // Storage is never reset: stale contents are flushed before any output depends on them.
    always_ff @(posedge clk) begin
        if (nms_data_in_valid) begin
            lb1_q[col_q] <= {nms_mag_in, nms_dir_in};
            lb2_q[col_q] <= lb1_q[col_q];
            win_q        <= win_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FILL;
            col_q          <= '0;
            row_q          <= '0;
            nms_mag_out    <= '0;
            nms_dir_out    <= '0;
            nms_out_valid  <= 1'b0;
            nms_frame_done <= 1'b0;
        end else begin
            nms_out_valid  <= emit;
            nms_frame_done <= emit && col_last && row_last;
            if (emit) begin
                nms_mag_out <= keep ? c_mag : 11'd0;
                nms_dir_out <= c_dir;
            end
            if (nms_data_in_valid) begin
                col_q <= col_last ? '0 : col_q + CW'(1);
                if (col_last) begin
                    row_q <= row_last ? '0 : row_q + RW'(1);
                    if (row_last) state_q <= FILL;
                    else if (row_q == RW'(1)) state_q <= RUN;
                end
            end
        end
    end
endmodule
